// File: rtl/reorder_buffer_mc_pkg.sv
// Shared definitions for the multi-commit reorder buffer:
// entry type codes, default geometry and redirect offsets.
package reorder_buffer_mc_pkg;

    localparam int ROB_DEPTH    = 16;
    localparam int ROB_ADDR_W   = 4;
    localparam int ROB_WB_PORTS = 2;
    localparam int ROB_COMMIT_W = 2;

    localparam logic [31:0] PC_STEP_C = 32'd2;
    localparam logic [31:0] PC_STEP_N = 32'd4;

    typedef enum logic [2:0] {
        T_TOREG  = 3'd0,
        T_LOAD   = 3'd1,
        T_STORE  = 3'd2,
        T_BRANCH = 3'd3,
        T_ELSE   = 3'd4,
        T_EXIT   = 3'd5
    } rob_type_e;

    typedef struct packed {
        logic        busy;
        logic        ready;
        rob_type_e   typ;
        logic        jalr;
        logic        is_c;
        logic        pred;
        logic [4:0]  rd;
        logic [31:0] value;
        logic [31:0] pc;
        logic [31:0] addr;
    } rob_entry_t;

    function automatic logic writes_reg(input rob_type_e t);
        return (t == T_TOREG) || (t == T_LOAD) || (t == T_ELSE);
    endfunction

    // Control entries may only retire from the head slot.
    function automatic logic is_ctrl(input rob_entry_t e);
        return (e.typ == T_BRANCH) || (e.typ == T_EXIT) || e.jalr;
    endfunction

endpackage

// File: rtl/rob_commit_sel.sv
// Per-slot commit enable chain for the reorder buffer head window.
// A slot fires only if every older slot fired and it is eligible.
module rob_commit_sel #(
    parameter int COMMIT_W = 2,
    parameter int ADDR_W   = 4
) (
    input  logic                en_i,
    input  logic [ADDR_W:0]     count_i,
    input  logic [COMMIT_W-1:0] rdy_i,
    input  logic [COMMIT_W-1:0] ctrl_i,
    output logic [COMMIT_W-1:0] fire_o,
    output logic [2:0]          n_o
);

    logic go;

    always_comb begin
        go     = en_i;
        fire_o = '0;
        n_o    = '0;
        for (int k = 0; k < COMMIT_W; k++) begin
            fire_o[k] = go
                && ((ADDR_W+1)'(k) < count_i)
                && rdy_i[k]
                && ((k == 0) || !ctrl_i[k]);
            // a retiring control entry closes the window
            go  = fire_o[k] && !ctrl_i[k];
            n_o = n_o + {2'b00, fire_o[k]};
        end
    end

endmodule

// File: rtl/reorder_buffer_mc.sv
// Reorder buffer with multi-slot in-order retirement, several
// write-back channels, operand bypass and registered redirect.
import reorder_buffer_mc_pkg::*;

module reorder_buffer_mc #(
    parameter int DEPTH    = ROB_DEPTH,
    parameter int ADDR_W   = ROB_ADDR_W,
    parameter int WB_PORTS = ROB_WB_PORTS,
    parameter int COMMIT_W = ROB_COMMIT_W
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic                       rdy_in,
    input  logic                       iss_valid,
    input  logic                       iss_ready,
    input  logic [2:0]                 iss_type,
    input  logic                       iss_is_jalr,
    input  logic                       iss_is_c,
    input  logic [4:0]                 iss_rd,
    input  logic [31:0]                iss_value,
    input  logic [31:0]                iss_pc,
    input  logic [31:0]                iss_addr,
    input  logic                       iss_pred_jump,
    output logic [ADDR_W-1:0]          iss_id,
    output logic                       rob_full,
    output logic [ADDR_W:0]            rob_count,
    input  logic [2*ADDR_W-1:0]        qry_id,
    output logic [1:0]                 qry_ready,
    output logic [63:0]                qry_value,
    input  logic [WB_PORTS-1:0]        wb_valid,
    input  logic [WB_PORTS*ADDR_W-1:0] wb_id,
    input  logic [WB_PORTS*32-1:0]     wb_val,
    output logic                       rf_issue,
    output logic [4:0]                 rf_issue_rd,
    output logic [ADDR_W-1:0]          rf_new_dep,
    output logic [COMMIT_W-1:0]        cm_valid,
    output logic [COMMIT_W*5-1:0]      cm_rd,
    output logic [COMMIT_W*ADDR_W-1:0] cm_id,
    output logic [COMMIT_W*32-1:0]     cm_value,
    output logic                       lsb_head_valid,
    output logic [ADDR_W-1:0]          lsb_head_id,
    output logic                       clear,
    output logic [31:0]                new_pc,
    output logic                       bp_valid,
    output logic [31:0]                bp_pc,
    output logic                       bp_taken
);

    rob_entry_t        ent_q [DEPTH];
    rob_entry_t        ent_d [DEPTH];
    logic [ADDR_W-1:0] head_q, head_d;
    logic [ADDR_W-1:0] tail_q, tail_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              clear_q, clear_d;
    logic [31:0]       new_pc_q, new_pc_d;
    logic              bp_valid_q, bp_valid_d;
    logic [31:0]       bp_pc_q, bp_pc_d;
    logic              bp_taken_q, bp_taken_d;

    logic              full;
    logic              en;
    logic              iss_go;
    rob_type_e         iss_t;
    logic [DEPTH-1:0]  wb_hit;
    logic [ADDR_W-1:0] slot_id [COMMIT_W];
    rob_entry_t        slot_e  [COMMIT_W];
    logic [COMMIT_W-1:0] slot_rdy;
    logic [COMMIT_W-1:0] slot_ctl;
    logic [COMMIT_W-1:0] fire;
    logic [2:0]        n_ret;
    logic              br_taken;

    assign full   = (count_q == (ADDR_W+1)'(DEPTH));
    assign en     = rdy_in && rst_n_in && !clear_q;
    assign iss_go = en && iss_valid && !full;
    assign iss_t  = rob_type_e'(iss_type);

    always_comb begin
        wb_hit = '0;
        for (int c = 0; c < WB_PORTS; c++) begin
            if (wb_valid[c]) begin
                wb_hit[wb_id[c*ADDR_W +: ADDR_W]] = 1'b1;
            end
        end
    end

    // An entry being written back this cycle is not yet eligible.
    always_comb begin
        for (int k = 0; k < COMMIT_W; k++) begin
            slot_id[k]  = head_q + ADDR_W'(k);
            slot_e[k]   = ent_q[slot_id[k]];
            slot_rdy[k] = slot_e[k].busy && slot_e[k].ready
                && !wb_hit[slot_id[k]];
            slot_ctl[k] = is_ctrl(slot_e[k]);
        end
    end

    rob_commit_sel #(
        .COMMIT_W (COMMIT_W),
        .ADDR_W   (ADDR_W)
    ) u_commit_sel (
        .en_i    (en),
        .count_i (count_q),
        .rdy_i   (slot_rdy),
        .ctrl_i  (slot_ctl),
        .fire_o  (fire),
        .n_o     (n_ret)
    );

    always_comb begin
        cm_valid = '0;
        cm_rd    = '0;
        cm_id    = '0;
        cm_value = '0;
        for (int k = 0; k < COMMIT_W; k++) begin
            cm_valid[k] = fire[k] && writes_reg(slot_e[k].typ);
            cm_id[k*ADDR_W +: ADDR_W] = slot_id[k];
            cm_value[k*32 +: 32]      = slot_e[k].value;
            if (cm_valid[k]) begin
                cm_rd[k*5 +: 5] = slot_e[k].rd;
            end
        end
    end

    // Stored value first, then channels high to low so ch0 wins.
    always_comb begin
        qry_ready = '0;
        qry_value = '0;
        for (int q = 0; q < 2; q++) begin
            if (ent_q[qry_id[q*ADDR_W +: ADDR_W]].ready) begin
                qry_ready[q]         = 1'b1;
                qry_value[q*32 +: 32] =
                    ent_q[qry_id[q*ADDR_W +: ADDR_W]].value;
            end
            for (int c = WB_PORTS - 1; c >= 0; c--) begin
                if (wb_valid[c] && (wb_id[c*ADDR_W +: ADDR_W]
                        == qry_id[q*ADDR_W +: ADDR_W])) begin
                    qry_ready[q]         = 1'b1;
                    qry_value[q*32 +: 32] = wb_val[c*32 +: 32];
                end
            end
        end
    end

    assign br_taken = |slot_e[0].value;

    always_comb begin
        ent_d      = ent_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        clear_d    = clear_q;
        new_pc_d   = new_pc_q;
        bp_valid_d = bp_valid_q;
        bp_pc_d    = bp_pc_q;
        bp_taken_d = bp_taken_q;
        if (rdy_in) begin
            clear_d    = 1'b0;
            bp_valid_d = 1'b0;
            if (clear_q) begin
                for (int e = 0; e < DEPTH; e++) begin
                    ent_d[e].busy  = 1'b0;
                    ent_d[e].ready = 1'b0;
                end
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end else begin
                for (int k = 0; k < COMMIT_W; k++) begin
                    if (fire[k]) begin
                        ent_d[slot_id[k]].busy  = 1'b0;
                        ent_d[slot_id[k]].ready = 1'b0;
                    end
                end
                if (fire[0] && slot_e[0].typ == T_BRANCH) begin
                    bp_valid_d = 1'b1;
                    bp_pc_d    = slot_e[0].pc;
                    bp_taken_d = br_taken;
                    if (br_taken != slot_e[0].pred) begin
                        clear_d  = 1'b1;
                        new_pc_d = br_taken ? slot_e[0].addr
                            : slot_e[0].pc
                            + (slot_e[0].is_c ? PC_STEP_C : PC_STEP_N);
                    end
                end else if (fire[0] && slot_e[0].jalr) begin
                    clear_d  = 1'b1;
                    new_pc_d = slot_e[0].addr;
                end
                for (int c = WB_PORTS - 1; c >= 0; c--) begin
                    if (wb_valid[c]
                            && ent_q[wb_id[c*ADDR_W +: ADDR_W]].busy) begin
                        ent_d[wb_id[c*ADDR_W +: ADDR_W]].ready = 1'b1;
                        if (ent_q[wb_id[c*ADDR_W +: ADDR_W]].jalr) begin
                            ent_d[wb_id[c*ADDR_W +: ADDR_W]].addr =
                                wb_val[c*32 +: 32];
                        end else begin
                            ent_d[wb_id[c*ADDR_W +: ADDR_W]].value =
                                wb_val[c*32 +: 32];
                        end
                    end
                end
                if (iss_go) begin
                    ent_d[tail_q] = '{
                        busy:  1'b1,
                        ready: iss_ready,
                        typ:   iss_t,
                        jalr:  iss_is_jalr,
                        is_c:  iss_is_c,
                        pred:  iss_pred_jump,
                        rd:    iss_rd,
                        value: iss_value,
                        pc:    iss_pc,
                        addr:  iss_addr
                    };
                    tail_d = tail_q + 1'b1;
                end
                head_d  = head_q + ADDR_W'(n_ret);
                count_d = count_q + (ADDR_W+1)'(iss_go)
                    - (ADDR_W+1)'(n_ret);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            for (int e = 0; e < DEPTH; e++) begin
                ent_q[e] <= '0;
            end
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            clear_q    <= 1'b0;
            new_pc_q   <= '0;
            bp_valid_q <= 1'b0;
            bp_pc_q    <= '0;
            bp_taken_q <= 1'b0;
        end else begin
            ent_q      <= ent_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            clear_q    <= clear_d;
            new_pc_q   <= new_pc_d;
            bp_valid_q <= bp_valid_d;
            bp_pc_q    <= bp_pc_d;
            bp_taken_q <= bp_taken_d;
        end
    end

    assign iss_id         = tail_q;
    assign rob_full       = full;
    assign rob_count      = count_q;
    assign rf_issue       = iss_go && writes_reg(iss_t);
    assign rf_issue_rd    = rf_issue ? iss_rd : 5'd0;
    assign rf_new_dep     = rf_issue ? tail_q : '0;
    assign lsb_head_valid = (count_q != '0)
        && (ent_q[head_q].typ == T_LOAD || ent_q[head_q].typ == T_STORE);
    assign lsb_head_id    = head_q;
    assign clear          = clear_q;
    assign new_pc         = new_pc_q;
    assign bp_valid       = bp_valid_q;
    assign bp_pc          = bp_pc_q;
    assign bp_taken       = bp_taken_q;

endmodule

// File: tb/tb_reorder_buffer_mc.sv
// Scoreboard bench for reorder_buffer_mc: a queue-based program-order
// model predicts every cycle; a negedge monitor compares.
module tb_reorder_buffer_mc;
    import reorder_buffer_mc_pkg::*;

    localparam int D  = 16;
    localparam int AW = 4;
    localparam int WB = 2;
    localparam int CW = 2;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic rst_n_in, rdy_in, iss_valid, iss_ready, iss_is_jalr, iss_is_c;
    logic iss_pred_jump;
    logic [2:0] iss_type;
    logic [4:0] iss_rd;
    logic [31:0] iss_value, iss_pc, iss_addr;
    logic [AW-1:0] iss_id;
    logic rob_full;
    logic [AW:0] rob_count;
    logic [2*AW-1:0] qry_id;
    logic [1:0] qry_ready;
    logic [63:0] qry_value;
    logic [WB-1:0] wb_valid;
    logic [WB*AW-1:0] wb_id;
    logic [WB*32-1:0] wb_val;
    logic rf_issue;
    logic [4:0] rf_issue_rd;
    logic [AW-1:0] rf_new_dep;
    logic [CW-1:0] cm_valid;
    logic [CW*5-1:0] cm_rd;
    logic [CW*AW-1:0] cm_id;
    logic [CW*32-1:0] cm_value;
    logic lsb_head_valid;
    logic [AW-1:0] lsb_head_id;
    logic clear, bp_valid, bp_taken;
    logic [31:0] new_pc, bp_pc;

    reorder_buffer_mc dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_type(iss_type), .iss_is_jalr(iss_is_jalr),
        .iss_is_c(iss_is_c), .iss_rd(iss_rd), .iss_value(iss_value),
        .iss_pc(iss_pc), .iss_addr(iss_addr),
        .iss_pred_jump(iss_pred_jump), .iss_id(iss_id),
        .rob_full(rob_full), .rob_count(rob_count),
        .qry_id(qry_id), .qry_ready(qry_ready), .qry_value(qry_value),
        .wb_valid(wb_valid), .wb_id(wb_id), .wb_val(wb_val),
        .rf_issue(rf_issue), .rf_issue_rd(rf_issue_rd),
        .rf_new_dep(rf_new_dep), .cm_valid(cm_valid), .cm_rd(cm_rd),
        .cm_id(cm_id), .cm_value(cm_value),
        .lsb_head_valid(lsb_head_valid), .lsb_head_id(lsb_head_id),
        .clear(clear), .new_pc(new_pc), .bp_valid(bp_valid),
        .bp_pc(bp_pc), .bp_taken(bp_taken)
    );

    typedef struct {
        int id; int typ; bit jalr; bit isc; bit pred; bit ready;
        int rd; logic [31:0] value; logic [31:0] pc; logic [31:0] addr;
    } ment_t;

    typedef struct {
        int count; bit full; int iss_id; bit [1:0] qr; logic [63:0] qv;
        bit lsbv; int lsbid; bit rfi; int rfrd; int rfdep; bit [1:0] cmv;
        bit clr; logic [31:0] npc; bit bpv; bit bpt; logic [31:0] bppc;
    } exp_t;

    typedef struct { int id; int rd; logic [31:0] value; } cm_t;

    ment_t mq[$];
    int m_head = 0;
    bit m_clear = 0, m_bpv = 0, m_bpt = 0;
    logic [31:0] m_npc = 0, m_bppc = 0;
    exp_t expq[$];
    cm_t cmq[$];
    int errors = 0;
    int checks = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int m_tail();
        return (m_head + mq.size()) % D;
    endfunction

    function automatic int off_of(int id);
        return (id - m_head + D) % D;
    endfunction

    function automatic bit is_regw(int t);
        return t == 0 || t == 1 || t == 4;
    endfunction

    function automatic bit is_ctl(ment_t e);
        return e.typ == 3 || e.typ == 5 || e.jalr;
    endfunction

    function automatic bit wbhit(int id);
        for (int c = 0; c < WB; c++)
            if (wb_valid[c] && int'(wb_id[c*AW +: AW]) == id) return 1;
        return 0;
    endfunction

    // Predict this cycle's outputs, then advance to the next edge.
    task automatic model_step();
        exp_t e;
        ment_t x;
        cm_t cr;
        int tail, qid, o, nret, wid;
        bit go, tk;
        tail = m_tail();
        e.count = mq.size();
        e.full = (mq.size() == D);
        e.iss_id = tail;
        e.qr = 0;
        e.qv = 0;
        for (int q = 0; q < 2; q++) begin
            qid = int'(qry_id[q*AW +: AW]);
            o = off_of(qid);
            if (o < mq.size() && mq[o].ready) begin
                e.qr[q] = 1;
                e.qv[q*32 +: 32] = mq[o].value;
            end
            for (int c = WB - 1; c >= 0; c--)
                if (wb_valid[c] && int'(wb_id[c*AW +: AW]) == qid) begin
                    e.qr[q] = 1;
                    e.qv[q*32 +: 32] = wb_val[c*32 +: 32];
                end
        end
        e.lsbv = mq.size() > 0 && (mq[0].typ == 1 || mq[0].typ == 2);
        e.lsbid = m_head;
        go = rst_n_in && rdy_in && !m_clear && iss_valid && mq.size() < D;
        e.rfi = go && is_regw(int'(iss_type));
        e.rfrd = e.rfi ? int'(iss_rd) : 0;
        e.rfdep = e.rfi ? tail : 0;
        e.clr = m_clear; e.npc = m_npc;
        e.bpv = m_bpv; e.bpt = m_bpt; e.bppc = m_bppc;
        e.cmv = 0;
        nret = 0;
        if (rst_n_in && rdy_in && !m_clear) begin
            for (int k = 0; k < CW && k < mq.size(); k++) begin
                x = mq[k];
                if (!x.ready || wbhit(x.id)) break;
                if (k > 0 && is_ctl(x)) break;
                nret++;
                if (is_regw(x.typ)) begin
                    e.cmv[k] = 1;
                    cr.id = x.id; cr.rd = x.rd; cr.value = x.value;
                    cmq.push_back(cr);
                end
                if (is_ctl(x)) break;
            end
        end
        expq.push_back(e);
        if (!rst_n_in) begin
            mq.delete(); m_head = 0; m_clear = 0; m_bpv = 0; m_bpt = 0;
            m_npc = 0; m_bppc = 0;
        end else if (rdy_in) begin
            if (m_clear) begin
                mq.delete(); m_head = 0; m_clear = 0; m_bpv = 0;
            end else begin
                m_bpv = 0;
                if (nret > 0 && mq[0].typ == 3) begin
                    tk = (mq[0].value != 0);
                    m_bpv = 1; m_bppc = mq[0].pc; m_bpt = tk;
                    if (tk != mq[0].pred) begin
                        m_clear = 1;
                        m_npc = tk ? mq[0].addr
                            : mq[0].pc + (mq[0].isc ? 2 : 4);
                    end
                end else if (nret > 0 && mq[0].jalr) begin
                    m_clear = 1;
                    m_npc = mq[0].addr;
                end
                for (int k = 0; k < nret; k++) void'(mq.pop_front());
                m_head = (m_head + nret) % D;
                for (int c = WB - 1; c >= 0; c--)
                    if (wb_valid[c]) begin
                        wid = int'(wb_id[c*AW +: AW]);
                        o = off_of(wid);
                        if (o < mq.size()) begin
                            mq[o].ready = 1;
                            if (mq[o].jalr) mq[o].addr = wb_val[c*32 +: 32];
                            else mq[o].value = wb_val[c*32 +: 32];
                        end
                    end
                if (go) begin
                    x.id = tail; x.typ = int'(iss_type); x.jalr = iss_is_jalr;
                    x.isc = iss_is_c; x.pred = iss_pred_jump;
                    x.ready = iss_ready; x.rd = int'(iss_rd);
                    x.value = iss_value; x.pc = iss_pc; x.addr = iss_addr;
                    mq.push_back(x);
                end
            end
        end
    endtask

    always @(negedge clk_in) begin
        exp_t e;
        cm_t c;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("count", 64'(rob_count), 64'(e.count));
            chk("full", 64'(rob_full), 64'(e.full));
            chk("iss_id", 64'(iss_id), 64'(e.iss_id));
            chk("qry_ready", 64'(qry_ready), 64'(e.qr));
            chk("qry_value", qry_value, e.qv);
            chk("lsb_valid", 64'(lsb_head_valid), 64'(e.lsbv));
            chk("lsb_id", 64'(lsb_head_id), 64'(e.lsbid));
            chk("rf_issue", 64'(rf_issue), 64'(e.rfi));
            chk("rf_rd", 64'(rf_issue_rd), 64'(e.rfrd));
            chk("rf_dep", 64'(rf_new_dep), 64'(e.rfdep));
            chk("cm_valid", 64'(cm_valid), 64'(e.cmv));
            chk("clear", 64'(clear), 64'(e.clr));
            chk("new_pc", 64'(new_pc), 64'(e.npc));
            chk("bp_valid", 64'(bp_valid), 64'(e.bpv));
            chk("bp_pc", 64'(bp_pc), 64'(e.bppc));
            chk("bp_taken", 64'(bp_taken), 64'(e.bpt));
            for (int k = 0; k < CW; k++) begin
                if (cm_valid[k] === 1'b1) begin
                    if (cmq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL cm_extra: slot %0d got commit want none", k);
                    end else begin
                        c = cmq.pop_front();
                        chk("cm_id", 64'(cm_id[k*AW +: AW]), 64'(c.id));
                        chk("cm_rd", 64'(cm_rd[k*5 +: 5]), 64'(c.rd));
                        chk("cm_value", 64'(cm_value[k*32 +: 32]), 64'(c.value));
                    end
                end else begin
                    chk("cm_rd_idle", 64'(cm_rd[k*5 +: 5]), 64'd0);
                end
            end
        end
    end

    task automatic cycle();
        model_step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle_inputs();
        rst_n_in = 1; rdy_in = 1; iss_valid = 0; iss_ready = 0;
        iss_type = 0; iss_is_jalr = 0; iss_is_c = 0; iss_rd = 0;
        iss_value = 0; iss_pc = 0; iss_addr = 0; iss_pred_jump = 0;
        wb_valid = 0; wb_id = 0; wb_val = 0;
        qry_id = 8'($urandom);
    endtask

    task automatic iss(int typ, bit rdy, int rd, logic [31:0] val,
                       logic [31:0] pc, logic [31:0] addr, bit pred,
                       bit jalr, bit isc);
        iss_valid = 1; iss_type = 3'(typ); iss_ready = rdy;
        iss_rd = 5'(rd); iss_value = val; iss_pc = pc; iss_addr = addr;
        iss_pred_jump = pred; iss_is_jalr = jalr; iss_is_c = isc;
    endtask

    task automatic wb(int ch, int id, logic [31:0] val);
        wb_valid[ch] = 1;
        wb_id[ch*AW +: AW] = AW'(id);
        wb_val[ch*32 +: 32] = val;
    endtask

    task automatic do_reset(int n);
        idle_inputs();
        rst_n_in = 0;
        repeat (n) cycle();
        rst_n_in = 1;
    endtask

    function automatic int pick_pending();
        int ids[$];
        foreach (mq[i]) if (!mq[i].ready) ids.push_back(mq[i].id);
        if (ids.size() == 0) return -1;
        return ids[$urandom_range(0, ids.size() - 1)];
    endfunction

    task automatic rand_wb();
        int p;
        wb_valid = 0;
        for (int c = 0; c < WB; c++) begin
            if ($urandom_range(0, 9) < 6) begin
                p = pick_pending();
                if (p < 0) p = $urandom_range(0, D - 1);
                wb(c, p, $urandom_range(0, 1) ? $urandom : $urandom_range(0, 1));
            end
        end
        if (wb_valid[0] && $urandom_range(0, 6) == 0)
            wb(1, int'(wb_id[AW-1:0]), $urandom);
    endtask

    task automatic rand_issue();
        int r;
        logic [31:0] pc;
        pc = {$urandom_range(0, 4095), 2'b00};
        iss_valid = 0;
        if ($urandom_range(0, 2) == 0) return;
        r = $urandom_range(0, 19);
        if (r < 8) iss(0, $urandom_range(0, 9) < 3, $urandom_range(0, 31), $urandom, pc, 0, 0, 0, 0);
        else if (r < 11) iss(1, 0, $urandom_range(0, 31), 0, pc, 0, 0, 0, 0);
        else if (r < 13) iss(2, $urandom_range(0, 1), 0, 0, pc, 0, 0, 0, 0);
        else if (r == 13) iss(3, $urandom_range(0, 1), 0, $urandom_range(0, 1), pc, $urandom, $urandom_range(0, 1), 0, $urandom_range(0, 1));
        else if (r == 14) iss(5, $urandom_range(0, 1), 0, 0, pc, 0, 0, 0, 0);
        else if (r < 19) iss(4, $urandom_range(0, 1), $urandom_range(0, 31), $urandom, pc, 0, 0, 0, 0);
        else iss(0, 0, $urandom_range(1, 31), pc + 4, pc, 0, 0, 1, 0);
    endtask

    initial begin
        idle_inputs();
        rst_n_in = 0;
        @(posedge clk_in);
        #1;
        do_reset(2);

        // fill to full, 17th issue rejected
        for (int i = 0; i < 17; i++) begin
            iss(0, 0, i + 1, i, 32'h1000 + 4 * i, 0, 0, 0, 0);
            cycle();
        end
        idle_inputs();
        cycle();
        do_reset(1);

        // dual retire of rd 5/6
        iss(0, 0, 5, 0, 32'h10, 0, 0, 0, 0); cycle();
        iss(0, 0, 6, 0, 32'h14, 0, 0, 0, 0); cycle();
        idle_inputs(); wb(0, 0, 32'hA); wb(1, 1, 32'hB); cycle();
        idle_inputs(); repeat (2) cycle();

        // branch behind a toreg entry, correctly predicted
        iss(0, 0, 7, 0, 32'h200, 0, 0, 0, 0); cycle();
        iss(3, 0, 0, 0, 32'h204, 32'h400, 1, 0, 0); cycle();
        idle_inputs(); wb(0, 2, 32'h7); wb(1, 3, 32'h1); cycle();
        idle_inputs(); repeat (3) cycle();

        // mispredicted not-taken branch, younger entry flushed
        iss(3, 1, 0, 0, 32'h100, 32'h300, 1, 0, 0); cycle();
        iss(0, 1, 9, 32'h99, 32'h104, 0, 0, 0, 0); cycle();
        idle_inputs(); repeat (3) cycle();

        // bypass and channel priority
        for (int i = 0; i < 4; i++) begin
            iss(1, 0, i + 1, 0, 32'h500 + 4 * i, 0, 0, 0, 0);
            cycle();
        end
        idle_inputs(); wb(1, 3, 32'h55); qry_id = {4'd3, 4'd3}; cycle();
        idle_inputs(); wb(0, 2, 32'h66); wb(1, 2, 32'h77);
        qry_id = {4'd2, 4'd3}; cycle();
        idle_inputs(); qry_id = {4'd3, 4'd0}; cycle();
        do_reset(1);

        // wrap with rdy_in stall
        for (int i = 0; i < 14; i++) begin
            iss(4, 1, i + 1, 32'h700 + i, 32'h600 + 4 * i, 0, 0, 0, 0);
            cycle();
        end
        idle_inputs(); repeat (3) cycle();
        for (int i = 0; i < 4; i++) begin
            iss(0, 0, 20 + i, 0, 32'h800 + 4 * i, 0, 0, 0, 0);
            cycle();
        end
        idle_inputs(); rdy_in = 0;
        wb(0, 14, 32'hE); wb(1, 15, 32'hF);
        iss(0, 1, 3, 3, 0, 0, 0, 0, 0);
        repeat (3) cycle();
        idle_inputs(); wb(0, 14, 32'hE); wb(1, 15, 32'hF); cycle();
        idle_inputs(); wb(0, 0, 32'h10); wb(1, 1, 32'h11); cycle();
        idle_inputs(); repeat (3) cycle();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            idle_inputs();
            rst_n_in = ($urandom_range(0, 399) != 0);
            rdy_in = ($urandom_range(0, 9) != 0);
            rand_issue();
            rand_wb();
            if ($urandom_range(0, 1)) qry_id[AW-1:0] = wb_id[AW-1:0];
            cycle();
        end

        // drain outstanding entries
        for (int n = 0; n < 80; n++) begin
            idle_inputs();
            rand_wb();
            cycle();
        end
        idle_inputs();
        repeat (4) cycle();
        chk("cm_drain", 64'(cmq.size()), 64'd0);
        chk("exp_drain", 64'(expq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
